// File: rtl/in_port.sv
// in_port: 8-bit debounced input port with sticky edge capture and a
// registered CPU read path.
//
// Pins pass through a two-flop synchronizer. The synchronized vector is
// debounced as a whole: any bit change restarts the run counter. A new
// vector is accepted into `stable` only after it has been seen
// DEBOUNCE_CYCLES+1 consecutive times. Each accept sets the sticky
// `changed` flag and ORs the newly risen/fallen bits into `rise`/`fall`.
//
// A read captures {changed, 7'b0, fall, rise, stable} from the values held
// before the edge, and clears the sticky fields at that same edge. If an
// accept lands on the same edge as a read, the read still returns the old
// values. The accept then wins: `changed` ends up set, and rise/fall keep
// only the edges from that accept.
module in_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  port,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        changed
);

  // Terminal count of the run counter. cnt stops at this value, so it
  // never exceeds DEBOUNCE_CYCLES-1.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] cand;
  logic [7:0] stable;
  logic [7:0] rise;
  logic [7:0] fall;
  logic [7:0] cnt;

  logic       sample_moved;
  logic       pending;
  logic       accept;
  logic [7:0] acc_rise;
  logic [7:0] acc_fall;
  logic [7:0] rise_base;
  logic [7:0] fall_base;
  logic [7:0] rise_next;
  logic [7:0] fall_next;
  logic       changed_next;
  logic [7:0] cnt_next;
  logic [31:0] snapshot;

  // Two-flop synchronizer. Only sync2 is consumed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= port;
      sync2 <= sync1;
    end
  end

  // Accept decision and the next sticky state. A read clears the sticky
  // fields first, and an accept on the same edge is then ORed on top.
  always_comb begin
    sample_moved = (sync2 != cand);
    pending      = (cand != stable);
    accept       = !sample_moved && pending && (cnt == CNT_LAST);

    acc_rise = cand & ~stable;
    acc_fall = ~cand & stable;

    rise_base = read_enable ? '0 : rise;
    fall_base = read_enable ? '0 : fall;

    rise_next    = accept ? (rise_base | acc_rise) : rise_base;
    fall_next    = accept ? (fall_base | acc_fall) : fall_base;
    changed_next = accept | (changed & ~read_enable);

    if (sample_moved || accept || !pending) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 8'd1;
    end

    snapshot = {changed, 7'b0, fall, rise, stable};
  end

  // Candidate tracking, run counter and stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      if (sample_moved) begin
        cand <= sync2;
      end
      if (accept) begin
        stable <= cand;
      end
      cnt <= cnt_next;
    end
  end

  // Sticky change and edge flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      rise    <= rise_next;
      fall    <= fall_next;
      changed <= changed_next;
    end
  end

  // Registered read port. read_data holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable) begin
        read_data <= snapshot;
      end
    end
  end

endmodule

// File: tb/tb_in_port.sv
// Self-checking bench for in_port. Two instances (D=4 and D=1) share one
// stimulus stream. A run-length behavioural model predicts read_data,
// read_valid and changed for each instance, and these are compared on every
// falling edge. Directed literal checks pin the model to known values.
module tb_in_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  port;
  logic        read_enable;
  logic [31:0] rd4, rd1;
  logic        rv4, rv1, ch4, ch1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  in_port #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .port(port), .read_enable(read_enable),
    .read_data(rd4), .read_valid(rv4), .changed(ch4)
  );

  in_port #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .port(port), .read_enable(read_enable),
    .read_data(rd1), .read_valid(rv1), .changed(ch1)
  );

  // Behavioural model state. m_last/m_run hold the current run of identical
  // synchronized samples. A run of DEBOUNCE_CYCLES+1 samples that differs
  // from stable gets accepted.
  int unsigned dv [2] = '{4, 1};
  logic [7:0]  m_s1, m_s2;
  logic [7:0]  m_last   [2];
  int          m_run    [2];
  logic [7:0]  m_stable [2];
  logic [7:0]  m_rise   [2];
  logic [7:0]  m_fall   [2];
  logic        m_chg    [2];
  logic [31:0] m_rd     [2];
  logic        m_rv     [2];
  bit          m_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_last[k]   = 8'h00;
        m_run[k]    = 1;
        m_stable[k] = 8'h00;
        m_rise[k]   = 8'h00;
        m_fall[k]   = 8'h00;
        m_chg[k]    = 1'b0;
        m_rd[k]     = 32'h0;
        m_rv[k]     = 1'b0;
      end else begin
        if (m_s2 == m_last[k]) begin
          if (m_run[k] < 1000) m_run[k]++;
        end else begin
          m_last[k] = m_s2;
          m_run[k]  = 1;
        end
        acc = (m_run[k] >= int'(dv[k]) + 1) && (m_last[k] != m_stable[k]);
        if (read_enable) begin
          m_rd[k]   = {m_chg[k], 7'b0, m_fall[k], m_rise[k], m_stable[k]};
          m_rv[k]   = 1'b1;
          m_chg[k]  = 1'b0;
          m_rise[k] = 8'h00;
          m_fall[k] = 8'h00;
        end else begin
          m_rv[k] = 1'b0;
        end
        if (acc) begin
          m_rise[k]   = m_rise[k] | (m_last[k] & ~m_stable[k]);
          m_fall[k]   = m_fall[k] | (~m_last[k] & m_stable[k]);
          m_stable[k] = m_last[k];
          m_chg[k]    = 1'b1;
        end
      end
    end
    if (rst) begin
      m_s1 = 8'h00;
      m_s2 = 8'h00;
      m_ready = 1'b1;
    end else begin
      m_s2 = m_s1;
      m_s1 = port;
    end
  endtask

  // Model advances on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        chk("d4_read_data",  rd4, m_rd[0]);
        chk("d4_read_valid", 32'(rv4), 32'(m_rv[0]));
        chk("d4_changed",    32'(ch4), 32'(m_chg[0]));
        chk("d1_read_data",  rd1, m_rd[1]);
        chk("d1_read_valid", 32'(rv1), 32'(m_rv[1]));
        chk("d1_changed",    32'(ch1), 32'(m_chg[1]));
      end
    end
  end

  // Issue one read strobe, called just after a falling edge. Returns the D=4
  // result sampled one edge later.
  task automatic do_read(output logic [31:0] d);
    read_enable = 1'b1;
    @(negedge clk);
    d = rd4;
    chk("rv_pulse", 32'(rv4), 32'd1);
    read_enable = 1'b0;
  endtask

  // Step through edges 1..7 and check when changed first appears for each
  // instance: edge 7 for D=4, edge 4 for D=1.
  task automatic latency_walk(input string tag);
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk({tag, "_d4_latency"}, 32'(ch4), 32'(e >= 7));
      chk({tag, "_d1_latency"}, 32'(ch1), 32'(e >= 4));
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  val;
    int          hold;

    rst = 1'b1;
    port = 8'h00;
    read_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_read_data",  rd4, 32'h0);
    chk("reset_read_valid", 32'(rv4), 32'd0);
    chk("reset_changed",    32'(ch4), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Read right after reset returns zero and pulses valid for one cycle.
    do_read(d);
    chk("read_after_reset", d, 32'h0000_0000);
    @(negedge clk);
    chk("valid_one_cycle", 32'(rv4), 32'd0);

    // 00 -> A5, latency and sticky fields.
    port = 8'hA5;
    latency_walk("a5");
    do_read(d);
    chk("a5_first_read", d, 32'h8000_A5A5);
    do_read(d);
    chk("a5_second_read", d, 32'h0000_00A5);

    // A5 -> 5A: every bit moves one way or the other.
    port = 8'h5A;
    repeat (10) @(negedge clk);
    do_read(d);
    chk("5a_read", d, 32'h80A5_5A5A);
    do_read(d);
    chk("5a_cleared", d, 32'h0000_005A);

    // Back to 00, then a short glitch that must be rejected.
    port = 8'h00;
    repeat (10) @(negedge clk);
    do_read(d);
    do_read(d);
    chk("zero_cleared", d, 32'h0000_0000);
    port = 8'h01;
    repeat (3) @(negedge clk);
    port = 8'h00;
    repeat (10) @(negedge clk);
    chk("glitch_changed", 32'(ch4), 32'd0);
    do_read(d);
    chk("glitch_read", d, 32'h0000_0000);

    // The same pulse held for 6 cycles is accepted, and so is its release.
    port = 8'h01;
    repeat (6) @(negedge clk);
    port = 8'h00;
    repeat (20) @(negedge clk);
    do_read(d);
    chk("pulse6_read", d, 32'h8001_0100);

    // A read on the same edge as an accept returns the old values.
    port = 8'hA5;
    repeat (6) @(negedge clk);
    do_read(d);
    chk("collide_read", d, 32'h0000_0000);
    chk("collide_changed", 32'(ch4), 32'd1);
    do_read(d);
    chk("collide_next_read", d, 32'h8000_A5A5);

    // Reset in mid-debounce of FF, followed by a full-latency accept.
    port = 8'hFF;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_read_data", rd4, 32'h0);
    chk("midrst_changed",   32'(ch4), 32'd0);
    rst = 1'b0;
    latency_walk("ff");
    do_read(d);
    chk("ff_read", d, 32'h8000_FFFF);

    // Randomized phase: mixed hold lengths, random reads and rare resets.
    for (int blk = 0; blk < 800; blk++) begin
      if ($urandom_range(0, 1) == 0) begin
        val = 8'($urandom);
      end else begin
        val = port ^ (8'h01 << $urandom_range(0, 7));
      end
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        port = val;
        read_enable = ($urandom_range(0, 3) == 0);
        rst = ($urandom_range(0, 299) == 0);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    read_enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
